gpca_ctrl: RTL
==============

# gpca_ctrl

Sequencing controller for the combinational `gpca` cellular arithmetic array. It accepts one operation request at a time: multiply, square, square root or divide. It formats the operands into the array's `X/P/A/B/C` inputs, holds them stable for a programmable settle time, then captures `F/S` into a result register returned over a valid/ready handshake. The block sits between the array and any sequential requester, so the deep ripple paths through the array never lie on a single-cycle path.

## Interface
- `SETTLE_CYCLES`, default 16: cycles the array inputs are held before `F/S` are sampled. Legal range is 1..255; 0 is a compile-time error.
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `req_valid`  in  1  — request present.
- `req_ready`  out  1  — controller can accept a request.
- `req_op`  in  2  — 0 MUL, 1 SQR, 2 SQRT, 3 DIV.
- `req_a`  in  18  — operand A: multiplier/base in bits [8:0]; radicand or dividend in bits [17:0].
- `req_b`  in  9  — operand B: multiplicand or divisor; ignored for SQR and SQRT.
- `rsp_valid`  out  1  — result available.
- `rsp_ready`  in  1  — consumer takes the result.
- `rsp_f`  out  9  — captured array `F`.
- `rsp_s`  out  19  — captured array `S`.
- `rsp_err`  out  1  — divide-by-zero flag; see Configuration.
- `busy`  out  1  — high in any state other than IDLE.
- `gpca_x`  out  1 — drives array `X`.
- `gpca_p`  out  9 — drives array `P`.
- `gpca_a`  out  18 — drives array `A`.
- `gpca_b`  out  19 — drives array `B`.
- `gpca_c`  out  19 — drives array `C`.
- `gpca_f`  in  9 — array `F`.
- `gpca_s`  in  19 — array `S`.
- Array buses are MSB-first: index 1 of each array bus maps to the controller's MSB.

## Operation
- FSM states: IDLE, SETTLE, DONE.
- IDLE → SETTLE when `req_valid && req_ready`. On that edge:
  - all `gpca_*` output registers load;
  - the counter loads `SETTLE_CYCLES-1`.
- SETTLE decrements the counter each cycle. On the edge where the counter is 0:
  - `rsp_f` ← `gpca_f`, `rsp_s` ← `gpca_s`;
  - state → DONE.
- DONE holds `rsp_valid`=1 with `rsp_f/rsp_s/rsp_err` stable until `rsp_ready`. Then state → IDLE.
- `req_ready` = (state==IDLE). No accept occurs in DONE, so back-to-back operations have a one-cycle IDLE bubble.
- Operand formatting is registered at accept:
  - MUL: X=0; P=`req_a[8:0]`; A=0; B=C=`{req_b,10'b0}`.
  - SQR: X=0; P=`req_a[8:0]`; A=0; B=`SQ_B`=19'b0011_1111_1111_1111_111; C=`SQ_C`=19'b0100_0000_0000_0000_000.
  - SQRT: X=1; P=0; A=`req_a` (right-justified by caller); B=`SQ_B`; C=`SQ_C`.
  - DIV: X=1; P=0; A=`req_a` (left-justified by caller); B=C=`{req_b,10'b0}`.
- `gpca_*` outputs hold their last value in IDLE and DONE. They change only at an accept.
- Reset values: all `gpca_*`=0, `rsp_*`=0, `rsp_valid`=0, `busy`=0, state=IDLE. `req_ready` is 1 in the first cycle after reset.
- Reset asserted in SETTLE or DONE aborts the operation. No response is issued and the result is discarded.
- A request in DONE is not accepted. The requester holds `req_valid` (standard valid/ready rules: request fields stable while `req_valid && !req_ready`).

## Timing
- Accept at edge N: `gpca_*` valid from cycle N+1. `rsp_valid` rises at cycle N+SETTLE_CYCLES+1.
- Minimum request-to-request period is SETTLE_CYCLES+2 cycles when `rsp_ready` is tied high.
- `rsp_valid` falls on the edge where `rsp_valid && rsp_ready`.

## Configuration
- `GPCA_DIVZERO_EN` defined:
  - DIV with `req_b`==0 goes directly IDLE→DONE on the accept edge;
  - `rsp_err`=1, `rsp_f`=0, `rsp_s`=0, `gpca_*` unchanged;
  - `rsp_valid` rises at cycle N+1.
  - `rsp_err` is 0 for every other response.
- `GPCA_DIVZERO_EN` undefined: no check is made, DIV by 0 runs a normal settle, and `rsp_err` is tied 0.

## Structure
- Package `gpca_ctrl_pkg` holds:
  - op enum (`OP_MUL`, `OP_SQR`, `OP_SQRT`, `OP_DIV`);
  - state enum;
  - constants `SQ_B` and `SQ_C`;
  - array widths 9/18/19.
- Sub-module `gpca_operand_fmt`: combinational map from `req_op/req_a/req_b` to `x/p/a/b/c`, registered by `gpca_ctrl`.
- The `gpca` array is instantiated by the parent, not inside this block.

## Test plan
- MUL `req_a`=5, `req_b`=7, SETTLE_CYCLES=16 → `gpca_x`=0, `gpca_p`=9'b000000101, `gpca_a`=0, `gpca_b`=`gpca_c`=19'b0000_0011_1000_0000_000; `rsp_valid` rises exactly 17 cycles after accept; `rsp_f/rsp_s` equal the array model's output.
- SQR 5 then SQRT `req_a`=18'd25, back-to-back with `rsp_ready`=1 → SQR: X=0, P=5, B=`SQ_B`, C=`SQ_C`. SQRT: X=1, P=0, A=25. The second accept occurs 18 cycles after the first.
- DIV `req_a`=18'b1100_0100_0000_0000_00, `req_b`=5 → X=1, P=0, A as given, B=C=19'b0000_0010_1000_0000_000.
- DIV `req_b`=0 → with `GPCA_DIVZERO_EN`: `rsp_valid` one cycle after accept, `rsp_err`=1, F=S=0. Without it: full settle, `rsp_err`=0.
- Backpressure: `rsp_ready`=0 for 5 cycles in DONE → `rsp_valid` and data stable, `req_ready`=0, and a pending request is accepted only after the response handshake.
- `rst` pulsed in SETTLE cycle 3 → next cycle all outputs at reset values, no `rsp_valid`, `req_ready`=1.

Source files
------------

// File: rtl/gpca_ctrl_pkg.sv
// Shared types and constants for the gpca sequencing controller.
package gpca_ctrl_pkg;
   localparam int F_W = 9;
   localparam int A_W = 18;
   localparam int S_W = 19;

   typedef enum logic [1:0] {OP_MUL = 2'd0, OP_SQR = 2'd1, OP_SQRT = 2'd2, OP_DIV = 2'd3} op_t;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SETTLE = 2'd1, ST_DONE = 2'd2} state_t;

   localparam logic [S_W-1:0] SQ_B = 19'b0011_1111_1111_1111_111;
   localparam logic [S_W-1:0] SQ_C = 19'b0100_0000_0000_0000_000;

   // Multiplicand/divisor sits at the top of the 19-bit B/C buses.
   function automatic logic [S_W-1:0] scale_b(input logic [F_W-1:0] v);
      return {v, 10'b0};
   endfunction
endpackage

// File: rtl/gpca_operand_fmt.sv
// Combinational map from an operation request to the array's X/P/A/B/C inputs.
module gpca_operand_fmt
   import gpca_ctrl_pkg::*;
(
   input  logic [1:0]     op,
   input  logic [A_W-1:0] a_in,
   input  logic [F_W-1:0] b_in,
   output logic           x,
   output logic [F_W-1:0] p,
   output logic [A_W-1:0] a,
   output logic [S_W-1:0] b,
   output logic [S_W-1:0] c
);
   always_comb begin
      x = 1'b0;
      p = '0;
      a = '0;
      b = scale_b(b_in);
      c = scale_b(b_in);
      case (op_t'(op))
         OP_MUL: p = a_in[F_W-1:0];
         OP_SQR: begin
            p = a_in[F_W-1:0];
            b = SQ_B;
            c = SQ_C;
         end
         OP_SQRT: begin
            x = 1'b1;
            a = a_in;
            b = SQ_B;
            c = SQ_C;
         end
         OP_DIV: begin
            x = 1'b1;
            a = a_in;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/gpca_ctrl.sv
// Sequencer for the gpca array: register operands, wait SETTLE_CYCLES, capture F/S.
// Optional macro GPCA_DIVZERO_EN: short-circuit DIV by zero with rsp_err=1.
module gpca_ctrl
   import gpca_ctrl_pkg::*;
#(
   parameter int SETTLE_CYCLES = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [1:0]     req_op,
   input  logic [A_W-1:0] req_a,
   input  logic [F_W-1:0] req_b,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic [F_W-1:0] rsp_f,
   output logic [S_W-1:0] rsp_s,
   output logic           rsp_err,
   output logic           busy,
   output logic           gpca_x,
   output logic [F_W-1:0] gpca_p,
   output logic [A_W-1:0] gpca_a,
   output logic [S_W-1:0] gpca_b,
   output logic [S_W-1:0] gpca_c,
   input  logic [F_W-1:0] gpca_f,
   input  logic [S_W-1:0] gpca_s
);
   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("gpca_ctrl: SETTLE_CYCLES must be 1..255");
   end

   localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);

   state_t         state;
   logic [7:0]     cnt;
   logic           fx;
   logic [F_W-1:0] fp;
   logic [A_W-1:0] fa;
   logic [S_W-1:0] fb, fc;

   gpca_operand_fmt u_fmt (
      .op   (req_op),
      .a_in (req_a),
      .b_in (req_b),
      .x    (fx),
      .p    (fp),
      .a    (fa),
      .b    (fb),
      .c    (fc)
   );

`ifdef GPCA_DIVZERO_EN
   logic err_q;
   assign rsp_err = err_q;
`else
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         gpca_x    <= 1'b0;
         gpca_p    <= '0;
         gpca_a    <= '0;
         gpca_b    <= '0;
         gpca_c    <= '0;
         rsp_f     <= '0;
         rsp_s     <= '0;
         rsp_valid <= 1'b0;
         busy      <= 1'b0;
         req_ready <= 1'b1;
`ifdef GPCA_DIVZERO_EN
         err_q     <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: if (req_valid) begin
`ifdef GPCA_DIVZERO_EN
               // Divide by zero skips the array entirely; gpca_* keep their old values.
               if (op_t'(req_op) == OP_DIV && req_b == '0) begin
                  rsp_f     <= '0;
                  rsp_s     <= '0;
                  err_q     <= 1'b1;
                  rsp_valid <= 1'b1;
                  busy      <= 1'b1;
                  req_ready <= 1'b0;
                  state     <= ST_DONE;
               end else
`endif
               begin
                  gpca_x    <= fx;
                  gpca_p    <= fp;
                  gpca_a    <= fa;
                  gpca_b    <= fb;
                  gpca_c    <= fc;
                  cnt       <= CNT_INIT;
                  busy      <= 1'b1;
                  req_ready <= 1'b0;
                  state     <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (cnt == '0) begin
                  rsp_f     <= gpca_f;
                  rsp_s     <= gpca_s;
                  rsp_valid <= 1'b1;
`ifdef GPCA_DIVZERO_EN
                  err_q     <= 1'b0;
`endif
                  state     <= ST_DONE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            ST_DONE: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
               req_ready <= 1'b1;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
